// File: rtl/output_device_bank.sv
// Memory-mapped bank of NUM_DEVICES output channels with per-channel pending/ack handshake,
// sticky overrun flags and a status/control register. All state changes on the falling clock edge.
module output_device_bank #(
    parameter int unsigned NUM_DEVICES = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ADDR_WIDTH-1:0]             address,
    input  logic [DATA_WIDTH-1:0]             value,
    input  logic [DATA_WIDTH/8-1:0]           byte_en,
    input  logic                              is_write,
    input  logic                              is_read,
    output logic [DATA_WIDTH-1:0]             read_value,
    output logic                              read_valid,
    output logic [NUM_DEVICES*DATA_WIDTH-1:0] device_values,
    output logic [NUM_DEVICES-1:0]            device_pending,
    input  logic [NUM_DEVICES-1:0]            device_ack,
    output logic [NUM_DEVICES-1:0]            overrun
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0]  ch_q [NUM_DEVICES];
    logic [NUM_DEVICES-1:0] pending_q, pending_d;
    logic [NUM_DEVICES-1:0] overrun_q, overrun_d;
    logic [NUM_DEVICES-1:0] hit_ch;
    logic [NUM_DEVICES-1:0] ch_wr;
    logic [NUM_DEVICES-1:0] ovr_clr;
    logic                   hit_st;
    logic [DATA_WIDTH-1:0]  status_word;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [DATA_WIDTH-1:0]  read_value_q;
    logic                   read_valid_q;

    assign hit_st = (address == ADDR_WIDTH'(BASE_ADDR + NUM_DEVICES));

    for (genvar i = 0; i < NUM_DEVICES; i++) begin : g_ch
        assign hit_ch[i] = (address == ADDR_WIDTH'(BASE_ADDR + i));
        // A write with no byte lanes enabled is not a real update.
        assign ch_wr[i]  = is_write & hit_ch[i] & (|byte_en);
        assign device_values[i*DATA_WIDTH +: DATA_WIDTH] = ch_q[i];

        always_ff @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ch_q[i] <= '0;
            end else if (ch_wr[i]) begin
                for (int k = 0; k < NumBytes; k++) begin
                    if (byte_en[k]) begin
                        ch_q[i][k*8 +: 8] <= value[k*8 +: 8];
                    end
                end
            end
        end
    end

    // Overrun flags live in status bits 16 and up, which needs a 32-bit data path.
    if (DATA_WIDTH >= 32) begin : g_status_full
        always_comb begin
            status_word = '0;
            status_word[NUM_DEVICES-1:0] = pending_q;
            status_word[16 +: NUM_DEVICES] = overrun_q;
        end
        assign ovr_clr = {NUM_DEVICES{is_write & hit_st}} & value[16 +: NUM_DEVICES];
    end else begin : g_status_min
        always_comb begin
            status_word = '0;
            status_word[NUM_DEVICES-1:0] = pending_q;
        end
        assign ovr_clr = '0;
    end

    always_comb begin
        // A write that lands on the same edge as an ack keeps the channel pending.
        pending_d = (pending_q & ~device_ack) | ch_wr;
        // A new overrun on the same edge as its W1C clear wins.
        overrun_d = (overrun_q & ~ovr_clr) | (ch_wr & pending_q & ~device_ack);
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_DEVICES; i++) begin
            if (hit_ch[i]) begin
                rd_data = ch_q[i];
            end
        end
        if (hit_st) begin
            rd_data = status_word;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            overrun_q    <= '0;
            read_value_q <= '0;
            read_valid_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            read_valid_q <= is_read;
            if (is_read) begin
                read_value_q <= rd_data;
            end
        end
    end

    assign device_pending = pending_q;
    assign overrun        = overrun_q;
    assign read_value     = read_value_q;
    assign read_valid     = read_valid_q;

endmodule

// File: tb/tb_output_device_bank.sv
// Directed bench for output_device_bank: inputs change on the rising edge, outputs are
// checked 1 ns after the falling (active) edge against hand-computed values.
module tb_output_device_bank;

    localparam int unsigned NumDev = 4;
    localparam int unsigned Dw     = 32;
    localparam int unsigned Aw     = 16;
    localparam int unsigned Base   = 'h40;

    localparam logic [15:0] AddrCh0 = 16'h0040;
    localparam logic [15:0] AddrCh1 = 16'h0041;
    localparam logic [15:0] AddrCh2 = 16'h0042;
    localparam logic [15:0] AddrCh3 = 16'h0043;
    localparam logic [15:0] AddrSt  = 16'h0044;
    localparam logic [15:0] AddrBad = 16'h0045;

    logic              clk;
    logic              rst_n;
    logic [Aw-1:0]     address;
    logic [Dw-1:0]     value;
    logic [Dw/8-1:0]   byte_en;
    logic              is_write;
    logic              is_read;
    logic [Dw-1:0]     read_value;
    logic              read_valid;
    logic [NumDev*Dw-1:0] device_values;
    logic [NumDev-1:0] device_pending;
    logic [NumDev-1:0] device_ack;
    logic [NumDev-1:0] overrun;

    int n_cmp;
    int n_err;

    output_device_bank #(
        .NUM_DEVICES(NumDev),
        .DATA_WIDTH (Dw),
        .ADDR_WIDTH (Aw),
        .BASE_ADDR  (Base)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .address       (address),
        .value         (value),
        .byte_en       (byte_en),
        .is_write      (is_write),
        .is_read       (is_read),
        .read_value    (read_value),
        .read_valid    (read_valid),
        .device_values (device_values),
        .device_pending(device_pending),
        .device_ack    (device_ack),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive on the rising edge, return 1 ns after the falling edge.
    task automatic bus(input logic [15:0] a, input logic [31:0] v, input logic [3:0] be,
                       input logic wr, input logic rd, input logic [3:0] ack);
        @(posedge clk);
        address    = a;
        value      = v;
        byte_en    = be;
        is_write   = wr;
        is_read    = rd;
        device_ack = ack;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus(16'h0000, 32'h0, 4'h0, 1'b0, 1'b0, 4'h0);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        address    = '0;
        value      = '0;
        byte_en    = '0;
        is_write   = 1'b0;
        is_read    = 1'b0;
        device_ack = '0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_values", device_values, 128'h0);
        check_eq("rst_pending", device_pending, 4'h0);
        check_eq("rst_overrun", overrun, 4'h0);
        check_eq("rst_rvalid", read_valid, 1'b0);
        check_eq("rst_rvalue", read_value, 32'h0);
        @(posedge clk);
        rst_n = 1'b1;

        // Full write to channel 1, then acknowledge it.
        bus(AddrCh1, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 4'h0);
        check_eq("ch1_value", device_values[63:32], 32'hDEADBEEF);
        check_eq("ch1_pending", device_pending, 4'b0010);
        bus(16'h0000, 32'h0, 4'h0, 1'b0, 1'b0, 4'b0010);
        check_eq("ch1_ack", device_pending, 4'b0000);

        // Partial byte write to channel 0.
        bus(AddrCh0, 32'h11223344, 4'hF, 1'b1, 1'b0, 4'h0);
        bus(16'h0000, 32'h0, 4'h0, 1'b0, 1'b0, 4'b0001);
        bus(AddrCh0, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0, 4'h0);
        check_eq("ch0_partial", device_values[31:0], 32'h11BB33DD);
        check_eq("ch0_partial_pend", device_pending, 4'b0001);
        bus(16'h0000, 32'h0, 4'h0, 1'b0, 1'b0, 4'b0001);
        bus(AddrCh0, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, 4'h0);
        check_eq("ch0_be0_value", device_values[31:0], 32'h11BB33DD);
        check_eq("ch0_be0_pend", device_pending, 4'b0000);

        // Plain read of channel 1, then read_valid must drop.
        bus(AddrCh1, 32'h0, 4'h0, 1'b0, 1'b1, 4'h0);
        check_eq("rd_ch1_value", read_value, 32'hDEADBEEF);
        check_eq("rd_ch1_valid", read_valid, 1'b1);
        idle();
        check_eq("rd_valid_drop", read_valid, 1'b0);

        // Double write to channel 2 without ack -> overrun, status read, W1C.
        bus(AddrCh2, 32'h00000001, 4'hF, 1'b1, 1'b0, 4'h0);
        check_eq("ch2_no_ovr", overrun, 4'b0000);
        bus(AddrCh2, 32'h00000002, 4'hF, 1'b1, 1'b0, 4'h0);
        check_eq("ch2_overrun", overrun, 4'b0100);
        bus(AddrSt, 32'h0, 4'h0, 1'b0, 1'b1, 4'h0);
        check_eq("status_read", read_value, 32'h00040004);
        check_eq("status_valid", read_valid, 1'b1);
        bus(AddrSt, 32'h00040000, 4'h0, 1'b1, 1'b0, 4'h0);
        check_eq("w1c_overrun", overrun, 4'b0000);
        check_eq("w1c_pending", device_pending, 4'b0100);
        bus(16'h0000, 32'h0, 4'h0, 1'b0, 1'b0, 4'b0100);
        check_eq("ch2_ack", device_pending, 4'b0000);

        // Same-edge write and ack on channel 3.
        bus(AddrCh3, 32'h00000033, 4'hF, 1'b1, 1'b0, 4'h0);
        bus(AddrCh3, 32'h00000044, 4'hF, 1'b1, 1'b0, 4'b1000);
        check_eq("ch3_wr_ack_pend", device_pending, 4'b1000);
        check_eq("ch3_wr_ack_ovr", overrun, 4'b0000);
        check_eq("ch3_wr_ack_val", device_values[127:96], 32'h00000044);

        // Read and write of channel 3 on the same edge returns the old contents.
        bus(AddrCh3, 32'h00000055, 4'hF, 1'b1, 1'b1, 4'b1000);
        check_eq("ch3_rw_old", read_value, 32'h00000044);
        check_eq("ch3_rw_valid", read_valid, 1'b1);
        check_eq("ch3_rw_new", device_values[127:96], 32'h00000055);
        check_eq("ch3_rw_ovr", overrun, 4'b0000);

        // Unmapped address: writes ignored, reads return zero with valid.
        bus(AddrBad, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0, 4'h0);
        check_eq("bad_wr_values", device_values,
                 {32'h00000055, 32'h00000002, 32'hDEADBEEF, 32'h11BB33DD});
        check_eq("bad_wr_pending", device_pending, 4'b1000);
        check_eq("bad_wr_overrun", overrun, 4'b0000);
        bus(AddrBad, 32'h0, 4'h0, 1'b0, 1'b1, 4'h0);
        check_eq("bad_rd_value", read_value, 32'h0);
        check_eq("bad_rd_valid", read_valid, 1'b1);

        // Create an overrun and a read result, then reset in the middle of a write.
        bus(AddrCh3, 32'h00000066, 4'hF, 1'b1, 1'b1, 4'h0);
        check_eq("pre_rst_ovr", overrun, 4'b1000);
        @(posedge clk);
        address  = AddrCh0;
        value    = 32'hCAFEF00D;
        byte_en  = 4'hF;
        is_write = 1'b1;
        is_read  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_values", device_values, 128'h0);
        check_eq("midrst_pending", device_pending, 4'h0);
        check_eq("midrst_overrun", overrun, 4'h0);
        check_eq("midrst_rvalid", read_valid, 1'b0);
        is_write = 1'b0;
        is_read  = 1'b0;
        @(posedge clk);
        rst_n = 1'b1;
        bus(16'h0000, 32'h0, 4'h0, 1'b0, 1'b0, 4'hF);
        check_eq("post_rst_ack", device_pending, 4'h0);
        check_eq("post_rst_values", device_values, 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
